// File: rtl/main_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : main_mem_pkg
//  Description : Shared types and default widths for the main-memory responder
//                (FSM state encoding, posted-write buffer entry layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package main_mem_pkg;

    localparam int c_ADDR_W = 12;
    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
    } wbuf_entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_wbuf_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wbuf_fifo
//  Description : Posted-write buffer. Synchronous FIFO of {addr, wdata}
//                entries; head is always visible, push and pop may share an
//                edge. DEPTH must be a power of two so the pointers wrap
//                naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wbuf_fifo
    import main_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  wbuf_entry_t push_entry,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output wbuf_entry_t head
);

    localparam int                  c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = 1;
    localparam logic [c_PTR_W:0]    c_CNT_ONE = 1;
    localparam logic [c_PTR_W:0]    c_CNT_MAX = DEPTH[c_PTR_W:0];

    wbuf_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign full      = (r_count == c_CNT_MAX);
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Entry storage: no reset needed, validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; a reset discards every buffered entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : main_mem_responder
//  Description : Slow main-memory model behind the cache. Single-word
//                requests over valid/ready; writes are posted into a small
//                buffer that drains one entry per cycle, reads wait for the
//                buffer to drain and then return data after LATENCY cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int LATENCY    = 3,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              busy
);

    localparam int               c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic                w_load_rsp;
    logic                r_active;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [ADDR_W-1:0]   r_rsp_addr;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    logic                w_req_fire;
    logic                w_rd_fire;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    wbuf_entry_t         w_push_entry;
    wbuf_entry_t         w_head;

    // r_active keeps req_ready low while reset is held and for no longer.
    assign req_ready  = r_active && (r_state == IDLE) && !w_full;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_addr   = r_rsp_addr;
    assign busy       = (r_state != IDLE) || !w_empty;

    assign w_req_fire = req_valid && req_ready;
    assign w_rd_fire  = w_req_fire && !req_we;
    assign w_push     = w_req_fire && req_we;
    assign w_pop      = !w_empty;

    assign w_push_entry.addr  = c_ADDR_W'(req_addr);
    assign w_push_entry.wdata = c_DATA_W'(req_wdata);

    mem_wbuf_fifo #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .full       (w_full),
        .empty      (w_empty),
        .head       (w_head)
    );

    // Commit the buffer head to the array every cycle the buffer holds data.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_mem[ADDR_W'(w_head.addr)] <= DATA_W'(w_head.wdata);
        end
    end

    // Next-state and latency-counter logic. A read that finds buffered
    // writes at accept goes through DRAIN, costing one cycle per entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_rsp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_fire) begin
                    if (!w_empty) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = ACCESS;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                    w_load_rsp  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter, latched read address and the registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_active    <= 1'b0;
            r_addr      <= '0;
            r_rsp_rdata <= '0;
            r_rsp_addr  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= 1'b1;
            if (w_rd_fire) begin
                r_addr <= req_addr;
            end
            if (w_load_rsp) begin
                r_rsp_rdata <= r_mem[r_addr];
                r_rsp_addr  <= r_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_mem_responder
//  Description : Self-checking bench: a transaction-level memory model
//                (write queue, sparse array, response due-cycle) checked
//                against the DUT every cycle, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_mem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic [11:0] rsp_addr;
    logic        busy;

    main_mem_responder #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .LATENCY    (LAT),
        .WBUF_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] m_mem [int];
    wr_t         m_wq [$];
    bit          m_active;
    bit          m_pend;
    bit          m_rsp;
    int          m_due;
    int          cyc = 0;
    logic [11:0] m_raddr;
    logic [11:0] m_out_addr;
    logic [31:0] m_out_data;
    bit          m_known;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_active && !m_pend && (m_wq.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_wq.delete();
        m_active   = 1'b0;
        m_pend     = 1'b0;
        m_rsp      = 1'b0;
        m_raddr    = '0;
        m_out_addr = '0;
        m_out_data = '0;
        m_known    = 1'b1;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_update();
        bit  rdy;
        int  pre;
        wr_t e;
        cyc++;
        if (!reset) begin
            model_reset();
            return;
        end
        rdy = m_ready();
        pre = m_wq.size();
        if (m_rsp && rsp_ready) begin
            m_rsp  = 1'b0;
            m_pend = 1'b0;
        end
        if (pre > 0) begin
            e = m_wq.pop_front();
            m_mem[int'(e.a)] = e.d;
        end
        if (req_valid && rdy) begin
            if (req_we) begin
                m_wq.push_back({req_addr, req_wdata});
            end else begin
                m_pend  = 1'b1;
                m_raddr = req_addr;
                m_due   = cyc + LAT + pre;
            end
        end
        if (m_pend && !m_rsp && cyc == m_due) begin
            m_rsp      = 1'b1;
            m_out_addr = m_raddr;
            m_known    = m_mem.exists(int'(m_raddr));
            m_out_data = m_known ? m_mem[int'(m_raddr)] : 32'h0;
        end
        m_active = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", req_ready, m_ready());
            chk("rsp_valid", rsp_valid, m_rsp);
            chk("busy", busy, m_pend || (m_wq.size() > 0));
            chk("rsp_addr", rsp_addr, m_out_addr);
            if (m_known) begin
                chk("rsp_rdata", rsp_rdata, m_out_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    // Leaves req_valid high so consecutive calls issue back-to-back.
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("wr_accept_wait", n < 20, 1'b1);
        step();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input int exp_lat);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk("rd_accept_wait", n < 20, 1'b1);
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk("rd_latency", n, exp_lat);
        chk("rd_data", rsp_rdata, exp);
        chk("rd_addr", rsp_addr, a);
        if (rsp_ready) begin
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        cmp_en = 1'b1;
        step();
        step();
        chk("reset_req_ready", req_ready, 1'b0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        reset = 1'b1;
        step();
        chk("idle_req_ready", req_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_rsp_valid", rsp_valid, 1'b0);

        // write then read on the next cycle: one drain cycle added
        wr(12'h005, 32'h0000_0005);
        rd(12'h005, 32'h0000_0005, LAT + 1);

        // back-to-back writes, then readback
        for (int i = 0; i < 6; i++) begin
            wr(12'(i), 32'h100 + 32'(i));
        end
        for (int i = 0; i < 6; i++) begin
            rd(12'(i), 32'h100 + 32'(i), (i == 0) ? LAT + 1 : LAT);
        end

        // youngest write to the same address wins
        wr(12'h032, 32'h14);
        wr(12'h032, 32'h1F4);
        rd(12'h032, 32'h0000_01F4, 4);

        // response stall
        wr(12'h063, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        step();
        step();
        rsp_ready = 1'b0;
        rd(12'h063, 32'hDEAD_BEEF, 3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_data", rsp_rdata, 32'hDEAD_BEEF);
            chk("stall_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        chk("release_valid", rsp_valid, 1'b0);
        chk("release_req_ready", req_ready, 1'b1);

        // reset with a buffered write: it must not commit
        wr(12'h0AA, 32'h1111_1111);
        req_valid = 1'b0;
        step();
        step();
        wr(12'h0AA, 32'h2222_2222);
        req_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_wbuf_busy", busy, 1'b0);
        chk("rst_wbuf_ready", req_ready, 1'b0);
        step();
        reset = 1'b1;
        step();
        rd(12'h0AA, 32'h1111_1111, 3);

        // reset while in ACCESS
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h010;
        step();
        req_valid = 1'b0;
        step();
        chk("access_busy", busy, 1'b1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_access_valid", rsp_valid, 1'b0);
        chk("rst_access_busy", busy, 1'b0);
        step();
        reset = 1'b1;
        step();

        // reset while in RESP: rsp_valid falls without a clock edge
        rsp_ready = 1'b0;
        rd(12'h005, 32'h0000_0105, 3);
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_resp_valid", rsp_valid, 1'b0);
        chk("rst_resp_busy", busy, 1'b0);
        chk("rst_resp_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        step();
        reset = 1'b1;
        step();
        step();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
